// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter. Characters enter a small FIFO through a
//   load/ready handshake and are serialised LSB-first as
//   start, DATA_BITS data, optional parity, STOP_BITS stop bits.
//   Frames are sent back-to-back while the FIFO holds data.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> parity state and generator compiled in, PARITY selects
//                  0 none / 1 odd / 2 even
//     undefined -> no parity logic, PARITY ignored, frames carry no parity bit
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   write strobe, accepted when load & ready
//   in     in   character to enqueue [DATA_BITS-1:0]
//   ready  out  FIFO not full
//   tx     out  serial line, registered, idle high
//   busy   out  frame on the line or FIFO non-empty
//   level  out  FIFO occupancy [$clog2(FIFO_DEPTH):0]
module uart_tx_buffered #(
  parameter int CLK_DIV    = 288,
  parameter int DATA_BITS  = 7,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [DATA_BITS-1:0]          in,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY != 0);
`endif

  if (CLK_DIV < 4 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_buffered: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 push, pop;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        baud_cnt;
  logic                 baud_tc;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign ready   = (level != FULL);
  assign push    = load & ready;
  assign baud_tc = (baud_cnt == BAUD_LAST);
  assign busy    = (state != S_IDLE) | (level != '0);

  // FIFO storage: data only, pointers and level carry the reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state; the pop happens on every edge that enters START so the
  // next frame starts straight out of the last stop-bit cycle
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:
        if (level != '0) begin
          state_nxt = S_START;
          pop       = 1'b1;
        end
      S_START:
        if (baud_tc) state_nxt = S_DATA;
      S_DATA:
        if (baud_tc && bit_cnt == DATA_LAST)
`ifdef UART_TX_PARITY_EN
          state_nxt = PAR_ON ? S_PARITY : S_STOP;
`else
          state_nxt = S_STOP;
`endif
`ifdef UART_TX_PARITY_EN
      S_PARITY:
        if (baud_tc) state_nxt = S_STOP;
`endif
      S_STOP:
        if (baud_tc && bit_cnt == STOP_LAST) begin
          if (level != '0) begin
            state_nxt = S_START;
            pop       = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line level for the current state
  always_comb begin
    tx_d = 1'b1;
    case (state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Baud and bit counters. The baud counter restarts at every bit
  // boundary so each bit is exactly CLK_DIV cycles with no drift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == S_IDLE || baud_tc) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (state_nxt != state) bit_cnt <= '0;
      else if (baud_tc)       bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shifter loads the FIFO head on pop; parity is taken from the same word
  always_ff @(posedge clk) begin
    if (pop)                           shreg <= mem[rptr];
    else if (state == S_DATA && baud_tc) shreg <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
    if (pop) par_bit <= (^mem[rptr]) ^ (PARITY == 1);
`endif
  end

  // tx register; the async reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx <= 1'b1;
    else        tx <= tx_d;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       load0 = 1'b0, ready0, tx0, busy0;
  logic [6:0] in0 = '0;
  logic [2:0] level0;
  logic       load1 = 1'b0, ready1, tx1, busy1;
  logic [7:0] in1 = '0;
  logic [2:0] level1;
  logic       load2 = 1'b0, ready2, tx2, busy2;
  logic [7:0] in2 = '0;
  logic [2:0] level2;

  int n_chk = 0;
  int n_fail = 0;
  logic lg [0:1023];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_DIV(DIV), .DATA_BITS(7), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load0), .in(in0),
    .ready(ready0), .tx(tx0), .busy(busy0), .level(level0));

  uart_tx_buffered #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(2), .PARITY(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .in(in1),
    .ready(ready1), .tx(tx1), .busy(busy1), .level(level1));

  uart_tx_buffered #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .in(in2),
    .ready(ready2), .tx(tx2), .busy(busy2), .level(level2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected tx waveform of one frame, bit c = line level c cycles after the
  // first start-bit cycle; bits past the frame are zero.
  function automatic void frame_model(input logic [7:0] d, input int nb, input int par,
                                      input int nstop, output logic [63:0] v, output int len);
    logic [15:0] bits;
    int          n;
    logic        p;
    bits = '0;
    n    = 0;
    p    = 1'b0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin
      bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (PAR_EN && par != 0) begin
      bits[n] = (par == 2) ? p : ~p;
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = 1'b1;
      n++;
    end
    v = '0;
    for (int c = 0; c < n * DIV; c++) v[c] = bits[c / DIV];
    len = n * DIV;
  endfunction

  function automatic logic [63:0] window(input int start, input int len);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = lg[start + i];
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mv;
    int          flen, f0, run;
    logic [6:0]  c [0:5];

    // ---------------- reset state
    step();
    step();
    check("rst_tx", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_level", level0, 0);
    check("rst_ready", ready0, 1);
    check("rst_tx_u1", tx1, 1);
    rst_n = 1'b1;
    step();

    // ---------------- single frame 7'h41, 7N1, CLK_DIV=4
    load0 = 1'b1; in0 = 7'h41;
    step();                                  // t=0, pushed
    load0 = 1'b0;
    check("f1_level_t0", level0, 1);
    check("f1_busy_t0", busy0, 1);
    check("f1_tx_t0", tx0, 1);
    step();                                  // t=1, popped, START entered
    check("f1_tx_t1", tx0, 1);
    check("f1_level_t1", level0, 0);
    for (int t = 2; t < 42; t++) begin
      step();
      lg[t - 2] = tx0;
      if (t == 36) check("f1_busy_t36", busy0, 1);
      if (t == 37) check("f1_busy_t37", busy0, 0);
    end
    check("f1_wave", window(0, 40), 64'hFFF00000F0);
    frame_model(8'h41, 7, 0, 1, mv, flen);
    check("f1_model", window(0, flen), mv);

    // ---------------- FIFO fill, drop while full, push across pop, back-to-back
    c[0] = 7'h11; c[1] = 7'h22; c[2] = 7'h33; c[3] = 7'h44; c[4] = 7'h55; c[5] = 7'h66;
    load0 = 1'b1; in0 = c[0];
    for (int t = 0; t < 226; t++) begin
      step();
      lg[t] = tx0;
      if (t < 4)       in0 = c[t + 1];
      else if (t < 38) in0 = c[5];
      else             load0 = 1'b0;
      case (t)
        0:  check("ff_level_t0", level0, 1);
        1:  check("ff_level_t1", level0, 1);
        2:  check("ff_level_t2", level0, 2);
        3:  begin check("ff_level_t3", level0, 3); check("ff_ready_t3", ready0, 1); end
        4:  begin check("ff_level_t4", level0, 4); check("ff_ready_t4", ready0, 0); end
        5:  begin check("ff_level_t5", level0, 4); check("ff_ready_t5", ready0, 0); end
        36: check("ff_level_t36", level0, 4);
        37: begin check("ff_level_t37", level0, 3); check("ff_ready_t37", ready0, 1); end
        38: begin check("ff_level_t38", level0, 4); check("ff_ready_t38", ready0, 0); end
        216: check("ff_busy_t216", busy0, 1);
        217: begin check("ff_busy_t217", busy0, 0); check("ff_level_t217", level0, 0); end
        default: ;
      endcase
    end
    for (int k = 0; k < 6; k++) begin
      frame_model({1'b0, c[k]}, 7, 0, 1, mv, flen);
      check($sformatf("ff_frame%0d", k), window(2 + 36 * k, flen), mv);
    end
    check("ff_idle_after", window(218, 8), 64'hFF);

    // ---------------- reset during data bit 3 with 2 characters queued
    load0 = 1'b1; in0 = 7'h05;
    step();                                  // t=0
    in0 = 7'h2A;
    step();                                  // t=1
    in0 = 7'h15;
    step();                                  // t=2
    load0 = 1'b0;
    check("rs_level_q", level0, 2);
    for (int t = 3; t <= 19; t++) begin
      step();
      if (t == 17) check("rs_tx_bit2", tx0, 1);
    end
    check("rs_tx_bit3", tx0, 0);
    rst_n = 1'b0;
    #1;
    check("rs_tx_async", tx0, 1);
    check("rs_level", level0, 0);
    check("rs_busy", busy0, 0);
    check("rs_ready", ready0, 1);
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 60; t++) begin
      step();
      lg[t] = tx0;
    end
    check("rs_line_idle", window(0, 60), 64'h0FFF_FFFF_FFFF_FFFF);
    check("rs_busy_after", busy0, 0);
    check("rs_level_after", level0, 0);
    load0 = 1'b1; in0 = 7'h7F;
    step();
    load0 = 1'b0;
    step();
    step();
    check("rs_new_start", tx0, 0);
    for (int t = 0; t < 40; t++) step();

    // ---------------- two stop bits, even parity (when built in), 2 queued frames
    load1 = 1'b1; in1 = 8'h05;
    step();                                  // t=0
    in1 = 8'h07;
    step();                                  // t=1
    load1 = 1'b0;
    lg[0] = 1'b1;
    lg[1] = tx1;
    frame_model(8'h05, 8, 2, 2, mv, f0);
    for (int t = 2; t < 2 + 2 * f0 + 8; t++) begin
      step();
      lg[t] = tx1;
    end
    check("sb_frame0", window(2, f0), mv);
    frame_model(8'h07, 8, 2, 2, mv, flen);
    check("sb_frame1", window(2 + f0, flen), mv);
    check("sb_len", flen, PAR_EN ? 12 * DIV : 11 * DIV);
    run = 0;
    for (int i = 1 + f0; i > 1 && lg[i] === 1'b1; i--) run++;
    check("sb_stop_run", run, 8);
    check("sb_busy_end", busy1, 0);

    // ---------------- odd parity (when built in) on 8'h07
    load2 = 1'b1; in2 = 8'h07;
    step();
    load2 = 1'b0;
    step();
    frame_model(8'h07, 8, 1, 1, mv, flen);
    for (int t = 0; t < flen + 4; t++) begin
      step();
      lg[t] = tx2;
    end
    check("op_frame", window(0, flen), mv);
    check("op_len", flen, PAR_EN ? 11 * DIV : 10 * DIV);
    check("op_idle_after", window(flen, 4), 64'hF);
    check("op_busy_end", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
